// File: rtl/fadd_sched.sv
// Shares one pipelined FP adder between two requesters with round-robin arbitration.
// A {valid,id,tag} tracking pipe runs alongside the adder so each result returns to its issuer.
module fadd_sched #(
  parameter int LATENCY = 7,
  parameter int TAG_W   = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             stall,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [31:0]      req0_a,
  input  logic [31:0]      req0_b,
  input  logic             req0_sub,
  input  logic             req0_neg,
  input  logic [TAG_W-1:0] req0_tag,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [31:0]      req1_a,
  input  logic [31:0]      req1_b,
  input  logic             req1_sub,
  input  logic             req1_neg,
  input  logic [TAG_W-1:0] req1_tag,
  output logic             add_clken,
  output logic [31:0]      add_ope1,
  output logic [31:0]      add_ope2,
  output logic             add_is_sub,
  output logic             add_is_neg,
  input  logic [31:0]      add_q,
  output logic             rsp_valid,
  output logic             rsp_id,
  output logic [TAG_W-1:0] rsp_tag,
  output logic [31:0]      rsp_data,
  output logic [3:0]       inflight,
  output logic             idle
);

  logic               gnt_any, gnt_id, accept, retire;
  logic               rr_ptr_q, rr_ptr_d;
  logic [LATENCY-1:0] stg_vld_q, stg_vld_d;
  logic [LATENCY-1:0] stg_id_q, stg_id_d;
  logic [TAG_W-1:0]   stg_tag_q [LATENCY];
  logic [TAG_W-1:0]   stg_tag_d [LATENCY];
  logic [3:0]         inflight_q, inflight_d;

  always_comb begin
    gnt_any = req0_valid | req1_valid;
    gnt_id  = req1_valid & (~req0_valid | rr_ptr_q);
    accept  = gnt_any & ~stall;
    retire  = stg_vld_q[LATENCY-1] & ~stall;
    // ready is also held low while rst_n is asserted, even if requests are pending
    req0_ready = req0_valid & ~gnt_id & ~stall & rst_n;
    req1_ready = gnt_id & ~stall & rst_n;
    add_clken  = ~stall;
    add_ope1   = gnt_id ? req1_a   : req0_a;
    add_ope2   = gnt_id ? req1_b   : req0_b;
    add_is_sub = gnt_id ? req1_sub : req0_sub;
    add_is_neg = gnt_id ? req1_neg : req0_neg;
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (accept && req0_valid && req1_valid) rr_ptr_d = ~gnt_id;
    stg_vld_d = stg_vld_q;
    stg_id_d  = stg_id_q;
    stg_tag_d = stg_tag_q;
    if (!stall) begin
      stg_vld_d[0] = accept;
      stg_id_d[0]  = gnt_id;
      stg_tag_d[0] = gnt_id ? req1_tag : req0_tag;
      for (int k = 1; k < LATENCY; k++) begin
        stg_vld_d[k] = stg_vld_q[k-1];
        stg_id_d[k]  = stg_id_q[k-1];
        stg_tag_d[k] = stg_tag_q[k-1];
      end
    end
    inflight_d = inflight_q + {3'b000, accept} - {3'b000, retire};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q   <= 1'b0;
      stg_vld_q  <= '0;
      stg_id_q   <= '0;
      inflight_q <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      stg_vld_q  <= stg_vld_d;
      stg_id_q   <= stg_id_d;
      inflight_q <= inflight_d;
    end
  end

  for (genvar gi = 0; gi < LATENCY; gi++) begin : g_tag
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) stg_tag_q[gi] <= '0;
      else        stg_tag_q[gi] <= stg_tag_d[gi];
    end
  end

  assign rsp_valid = retire;
  assign rsp_id    = stg_id_q[LATENCY-1];
  assign rsp_tag   = stg_tag_q[LATENCY-1];
  assign rsp_data  = add_q;
  assign inflight  = inflight_q;
  assign idle      = (inflight_q == 4'd0) & ~req0_valid & ~req1_valid;

endmodule
